// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: widths, the NOOP
// encoding used to fill an empty output slot, and the fetch FSM states.
package fetch_stage_pkg;

   localparam int PROGRAM_ADDRESS_WIDTH = 16;
   localparam int INSTRUCTION_WIDTH     = 32;

   // addi x0, x0, 0
   localparam logic [INSTRUCTION_WIDTH-1:0] NOOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_ISSUE = 2'd0,
      FS_WAIT  = 2'd1,
      FS_HALT  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps exactly one request to
// instruction memory in flight, and holds one fetched instruction for if_id.
//
// Handshake: o_imem_req is a one-cycle request that memory always accepts;
// the matching i_imem_rvalid arrives one or more cycles later. The output
// buffer is consumed on any cycle with o_valid=1 and i_stall=0.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [PROGRAM_ADDRESS_WIDTH-1:0] RESET_PC = '0,
   parameter logic [PROGRAM_ADDRESS_WIDTH-1:0] PC_STEP  = PROGRAM_ADDRESS_WIDTH'(4)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_stall,
   input  logic                             i_redirect,
   input  logic [PROGRAM_ADDRESS_WIDTH-1:0] i_redirect_pc,
   input  logic                             i_halt,
   output logic                             o_imem_req,
   output logic [PROGRAM_ADDRESS_WIDTH-1:0] o_imem_addr,
   input  logic                             i_imem_rvalid,
   input  logic [INSTRUCTION_WIDTH-1:0]     i_imem_rdata,
   output logic                             o_valid,
   output logic [PROGRAM_ADDRESS_WIDTH-1:0] o_pc,
   output logic [INSTRUCTION_WIDTH-1:0]     o_instruction,
   output logic [1:0]                       o_dbg_state
);

   localparam logic [PROGRAM_ADDRESS_WIDTH-1:0] ALIGN_MASK = PROGRAM_ADDRESS_WIDTH'(3);

   fetch_state_t                     state_q,     state_d;
   logic [PROGRAM_ADDRESS_WIDTH-1:0] pc_q,        pc_d;
   logic [PROGRAM_ADDRESS_WIDTH-1:0] req_pc_q,    req_pc_d;
   logic                             buf_valid_q, buf_valid_d;
   logic [PROGRAM_ADDRESS_WIDTH-1:0] buf_pc_q,    buf_pc_d;
   logic [INSTRUCTION_WIDTH-1:0]     buf_instr_q, buf_instr_d;
   logic                             kill_q,      kill_d;

   logic                             consume;
   logic                             req;
   logic [PROGRAM_ADDRESS_WIDTH-1:0] redirect_target;

   // Request decision, buffer drain and next-state selection for the fetch FSM.
   always_comb begin
      consume         = buf_valid_q & ~i_stall;
      redirect_target = i_redirect_pc & ~ALIGN_MASK;
      // A request needs a free (or freeing) buffer slot; reset low forces it off.
      req = rst & (state_q == FS_ISSUE) & (~buf_valid_q | consume)
            & ~i_redirect & ~i_halt;

      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      buf_valid_d = buf_valid_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      kill_d      = kill_q;

      if (consume) begin
         buf_valid_d = 1'b0;
      end

      unique case (state_q)
         FS_ISSUE: begin
            if (i_redirect) begin
               pc_d        = redirect_target;
               buf_valid_d = 1'b0;
            end else if (i_halt) begin
               state_d = FS_HALT;
            end else if (req) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + PC_STEP;
               state_d  = FS_WAIT;
            end
         end
         FS_WAIT: begin
            if (i_redirect) begin
               pc_d        = redirect_target;
               buf_valid_d = 1'b0;
               if (i_imem_rvalid) begin
                  // Response and redirect together: the response is stale.
                  kill_d  = 1'b0;
                  state_d = FS_ISSUE;
               end else begin
                  // Response still in flight: remember to discard it.
                  kill_d = 1'b1;
               end
            end else if (i_imem_rvalid) begin
               if (kill_q) begin
                  kill_d = 1'b0;
               end else begin
                  buf_valid_d = 1'b1;
                  buf_pc_d    = req_pc_q;
                  buf_instr_d = i_imem_rdata;
               end
               state_d = i_halt ? FS_HALT : FS_ISSUE;
            end
         end
         FS_HALT: begin
            // Terminal until reset; only the buffer drain above applies.
         end
         default: begin
            state_d = FS_ISSUE;
         end
      endcase
   end

   // All fetch state, reset asynchronously to the program entry point.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= FS_ISSUE;
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         buf_valid_q <= 1'b0;
         buf_pc_q    <= '0;
         buf_instr_q <= NOOP;
         kill_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         buf_valid_q <= buf_valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         kill_q      <= kill_d;
      end
   end

   assign o_imem_req    = req;
   assign o_imem_addr   = pc_q;
   assign o_valid       = buf_valid_q;
   assign o_pc          = buf_pc_q;
   assign o_instruction = buf_valid_q ? buf_instr_q : NOOP;
   assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a responder models instruction memory,
// the driver walks a fixed cycle schedule, and a monitor checks every
// request address and every consumed instruction against expected queues.
module tb_fetch_stage;

   localparam int AW = 16;
   localparam int IW = 32;
   localparam logic [31:0] NOOP_W   = 32'h0000_0013;
   localparam logic [31:0] ST_ISSUE = 32'd0;
   localparam logic [31:0] ST_HALT  = 32'd2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_stall = 1'b0;
   logic          i_redirect = 1'b0;
   logic [AW-1:0] i_redirect_pc = '0;
   logic          i_halt = 1'b0;
   logic          o_imem_req;
   logic [AW-1:0] o_imem_addr;
   logic          i_imem_rvalid = 1'b0;
   logic [IW-1:0] i_imem_rdata = '0;
   logic          o_valid;
   logic [AW-1:0] o_pc;
   logic [IW-1:0] o_instruction;
   logic [1:0]    o_dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int cur   = 0;
   int mem_lat = 1;

   logic [AW+IW-1:0] exp_q[$];
   logic [AW-1:0]    exp_req_q[$];

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .i_halt        (i_halt),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_valid       (o_valid),
      .o_pc          (o_pc),
      .o_instruction (o_instruction),
      .o_dbg_state   (o_dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
      case (a)
         16'h0000: mem = 32'h0050_0093;
         16'h0004: mem = 32'h0010_0113;
         16'h0008: mem = 32'h0020_8193;
         16'h000C: mem = 32'h0031_0233;
         16'h0010: mem = 32'hDEAD_BEEF;
         16'h0100: mem = 32'h00A0_0513;
         16'h0104: mem = 32'h00B0_0593;
         16'hFFFC: mem = 32'h00C0_0613;
         16'h0200: mem = 32'h0000_006F;
         default:  mem = 32'h0000_0013;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cur, act, exp);
      end
   endtask

   task automatic to_cycle(input int c);
      while (cur < c) begin
         @(posedge clk);
         #1;
         cur++;
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_o_valid", 32'(o_valid), 32'd0);
      check("rst_o_pc", 32'(o_pc), 32'd0);
      check("rst_o_instruction", o_instruction, NOOP_W);
      check("rst_o_imem_req", 32'(o_imem_req), 32'd0);
      check("rst_state", 32'(o_dbg_state), ST_ISSUE);
   endtask

   // Memory responder: answers each request after mem_lat cycles.
   initial begin
      logic [AW-1:0] a;
      int lat;
      forever begin
         @(negedge clk);
         if (rst && o_imem_req) begin
            a   = o_imem_addr;
            lat = mem_lat;
            @(posedge clk);
            #1;
            repeat (lat - 1) begin
               @(posedge clk);
               #1;
            end
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem(a);
            @(posedge clk);
            #1;
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = '0;
         end
      end
   end

   // Monitor / scoreboard: requests and consumed instructions.
   initial begin
      logic [AW+IW-1:0] e;
      logic [AW-1:0]    ea;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (o_imem_req) begin
               if (exp_req_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_req at cycle %0d: got addr 0x%04h, expected none", cur, o_imem_addr);
               end else begin
                  ea = exp_req_q.pop_front();
                  check("req_addr", 32'(o_imem_addr), 32'(ea));
               end
            end
            if (o_valid && !i_stall) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_consume at cycle %0d: got pc 0x%04h, expected none", cur, o_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("out_pc", 32'(o_pc), 32'(e[AW+IW-1:IW]));
                  check("out_instr", o_instruction, e[IW-1:0]);
               end
            end
         end
      end
   end

   // Driver: fixed cycle schedule, cycle 0 is the first cycle after reset release.
   initial begin
      exp_req_q = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010,
                    16'h0100, 16'h0104, 16'hFFFC, 16'h0000, 16'h0200};
      exp_q.push_back({16'h0000, 32'h0050_0093});
      exp_q.push_back({16'h0004, 32'h0010_0113});
      exp_q.push_back({16'h0008, 32'h0020_8193});
      exp_q.push_back({16'h000C, 32'h0031_0233});
      exp_q.push_back({16'h0100, 32'h00A0_0513});
      exp_q.push_back({16'hFFFC, 32'h00C0_0613});
      exp_q.push_back({16'h0200, 32'h0000_006F});

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst = 1'b1;
      cur = 0;

      // First requests: cycle 0 then cycle 2.
      @(negedge clk);
      check("c0_req", 32'(o_imem_req), 32'd1);
      check("c0_valid", 32'(o_valid), 32'd0);
      to_cycle(1);
      @(negedge clk);
      check("c1_req_idle", 32'(o_imem_req), 32'd0);
      to_cycle(2);
      @(negedge clk);
      check("c2_valid", 32'(o_valid), 32'd1);
      check("c2_req", 32'(o_imem_req), 32'd1);

      // Stall three cycles while 0x8 is buffered.
      for (int c = 6; c <= 8; c++) begin
         to_cycle(c);
         i_stall = 1'b1;
         @(negedge clk);
         check("stall_valid", 32'(o_valid), 32'd1);
         check("stall_pc", 32'(o_pc), 32'h8);
         check("stall_instr", o_instruction, 32'h0020_8193);
         check("stall_req", 32'(o_imem_req), 32'd0);
      end
      to_cycle(9);
      i_stall = 1'b0;
      @(negedge clk);
      check("unstall_req", 32'(o_imem_req), 32'd1);

      // Redirect while a slow response is in flight: response must be dropped.
      to_cycle(11);
      mem_lat = 2;
      to_cycle(12);
      mem_lat = 1;
      i_redirect    = 1'b1;
      i_redirect_pc = 16'h0103;
      @(negedge clk);
      check("wait_redirect_req", 32'(o_imem_req), 32'd0);
      to_cycle(13);
      i_redirect = 1'b0;
      @(negedge clk);
      check("killed_rvalid_seen", 32'(i_imem_rvalid), 32'd1);
      to_cycle(14);
      @(negedge clk);
      check("killed_valid", 32'(o_valid), 32'd0);
      check("killed_instr", o_instruction, NOOP_W);

      // Redirect in the same cycle as a response.
      to_cycle(17);
      i_redirect    = 1'b1;
      i_redirect_pc = 16'hFFFC;
      @(negedge clk);
      check("rv_redirect_rvalid_seen", 32'(i_imem_rvalid), 32'd1);
      to_cycle(18);
      i_redirect = 1'b0;
      @(negedge clk);
      check("rv_redirect_valid", 32'(o_valid), 32'd0);
      check("rv_redirect_req", 32'(o_imem_req), 32'd1);

      // Request to 0x0000 at cycle 20 follows 0xFFFC (wrap); redirect away from it.
      to_cycle(21);
      i_redirect    = 1'b1;
      i_redirect_pc = 16'h0200;
      to_cycle(22);
      i_redirect = 1'b0;
      @(negedge clk);
      check("wrap_drop_valid", 32'(o_valid), 32'd0);

      // Halt while the infinite-loop instruction is buffered.
      to_cycle(24);
      i_stall = 1'b1;
      i_halt  = 1'b1;
      @(negedge clk);
      check("halt_req", 32'(o_imem_req), 32'd0);
      check("halt_buf_instr", o_instruction, 32'h0000_006F);
      to_cycle(25);
      @(negedge clk);
      check("halt_state", 32'(o_dbg_state), ST_HALT);
      check("halt_valid_held", 32'(o_valid), 32'd1);
      to_cycle(26);
      i_stall = 1'b0;
      for (int c = 27; c <= 32; c++) begin
         to_cycle(c);
         if (c == 30) i_halt = 1'b0;
         @(negedge clk);
         check("halted_valid", 32'(o_valid), 32'd0);
         check("halted_instr", o_instruction, NOOP_W);
         check("halted_req", 32'(o_imem_req), 32'd0);
      end

      // Reset again: outputs return to reset values, fetch restarts at 0.
      to_cycle(33);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      to_cycle(35);
      rst = 1'b1;
      cur = 0;
      exp_req_q.push_back(16'h0000);
      @(negedge clk);
      check("rerun_req", 32'(o_imem_req), 32'd1);
      to_cycle(1);

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("exp_req_q_drained", 32'(exp_req_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 5-stage RISC-V pipeline: owns the program counter, issues single-outstanding requests to instruction memory and buffers one fetched instruction for the `if_id` stage register. It sits directly upstream of `if_id`, takes stall from the hazard logic, redirect from branch/jump resolution, and halt from `if_id`'s end-of-program flag.

## Interface
- `RESET_PC`, default 0: byte address of the first fetch.
- `PC_STEP`, default 4: byte increment per sequential fetch.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_stall` in 1: hold the current output instruction, issue no new request.
- `i_redirect` in 1: one-cycle pulse, flush and restart fetch at `i_redirect_pc`.
- `i_redirect_pc` in PROGRAM_ADDRESS_WIDTH: redirect target; bits [1:0] forced to 0.
- `i_halt` in 1: level; stop fetching permanently until reset.
- `o_imem_req` in/out out 1: request valid; memory accepts every request.
- `o_imem_addr` out PROGRAM_ADDRESS_WIDTH: request byte address (= PC register).
- `i_imem_rvalid` in 1: response valid, ≥1 cycle after request.
- `i_imem_rdata` in INSTRUCTION_WIDTH: response instruction.
- `o_valid` out 1: output buffer holds a real instruction.
- `o_pc` out PROGRAM_ADDRESS_WIDTH: address of the buffered instruction.
- `o_instruction` out INSTRUCTION_WIDTH: buffered instruction; NOOP when `o_valid`=0.

## Operation
- State: `pc`, `req_pc`, buffer `{buf_valid, buf_pc, buf_instr}`, `kill` flag, FSM `ISSUE`/`WAIT`/`HALT`.
- Reset values: state ISSUE, `pc`=RESET_PC, `buf_valid`=0, `buf_pc`=0, `buf_instr`=NOOP, `kill`=0; so `o_valid`=0, `o_pc`=0, `o_instruction`=NOOP; `o_imem_req` forced 0 while `rst` low.
- consume = `o_valid` & !`i_stall`; consume clears `buf_valid` unless refilled the same edge.
- ISSUE: `o_imem_req` = (!`buf_valid` | consume) & !`i_redirect` & !`i_halt`. On request: `req_pc`<=`pc`, `pc`<=`pc`+PC_STEP (wraps modulo 2^PROGRAM_ADDRESS_WIDTH), go WAIT. `i_halt` with no redirect: go HALT.
- WAIT: no request. On `i_imem_rvalid`: if `kill`, drop data, clear `kill`; else buffer <= {1, `req_pc`, `i_imem_rdata`}. Then go HALT if `i_halt`, else ISSUE.
- Redirect (priority over stall, consume, and response): `pc`<=`i_redirect_pc`&~3, `buf_valid`<=0. In WAIT without rvalid: set `kill`, stay WAIT. In WAIT with rvalid: drop response, go ISSUE. In ISSUE: no request, stay ISSUE. Ignored in HALT.
- HALT: no requests ever; buffer still drains on consume; exit only by reset.
- Exactly one outstanding request; a second is never issued before its response.

## Timing
- 1-cycle memory: req cycle N, rvalid N+1, `o_valid` N+2, next req N+2 if consumed at N+2 → 1 instruction per 2 cycles steady state.
- Redirect at cycle N (ISSUE, idle memory): first request to target at N+1, its instruction on outputs at N+3.
- Stall: outputs stable for the stall duration; at most one further request completes into... not issued: request only when buffer empty or consumed, so no response is lost.
- Reset mid-WAIT: in-flight response after reset release is not expected by memory contract; `kill`=0, FSM restarts in ISSUE.

## Structure
- Add `fetch_state_t` enum (ISSUE, WAIT, HALT) to `common`; reuse existing NOOP, PROGRAM_ADDRESS_WIDTH, INSTRUCTION_WIDTH.
- Single module, no sub-module; one `always_ff` with async active-low reset, combinational `o_imem_req`/output mux.

## Test plan
- Reset release, memory returns 0x00500093 at 0x0 then 0x00100113 at 0x4 with 1-cycle latency → requests at 0x0 (cycle 0), 0x4 (cycle 2); `o_valid`=1, `o_pc`=0x0 at cycle 2, `o_pc`=0x4 at cycle 4.
- `i_stall` high 3 cycles while `o_pc`=0x8 → outputs unchanged, `o_imem_req`=0 throughout; release → request 0xC next cycle.
- `i_redirect`=1, `i_redirect_pc`=0x103 during WAIT, rvalid 2 cycles later with 0xDEADBEEF → response dropped, `o_valid`=0, next request addr 0x100.
- Redirect same cycle as rvalid → response dropped, request to target next cycle, no stale `o_valid`.
- `i_halt` asserted while buffer holds 0x0000006F (INF_LOOP) → no further `o_imem_req`; after consume `o_instruction`=NOOP (0x00000013), `o_valid`=0 until reset.
- `pc`=0xFFFC at 16-bit width, sequential fetch → next request address 0x0000.
